// File: rtl/m_ttime_pkg.sv
// Shared types and constants for the cycle/instret accumulator.
// State encoding and CSR half-select codes.
package m_ttime_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CY_C = 2'b01,
    ST_CY_I = 2'b10
  } state_t;

  localparam logic [1:0] SEL_CYC_LO = 2'b00;
  localparam logic [1:0] SEL_CYC_HI = 2'b01;
  localparam logic [1:0] SEL_INS_LO = 2'b10;
  localparam logic [1:0] SEL_INS_HI = 2'b11;

endpackage

// File: rtl/m_ttime_acc_if.sv
// CSR req/ack access port of the accumulator.
// The master is the CSR requester, the slave is m_ttime_acc.
interface m_ttime_acc_if;
  logic        csr_req;
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ack;

  modport master (output csr_req, csr_we, csr_sel, csr_wdata,
                  input  csr_rdata, csr_ack);
  modport slave  (input  csr_req, csr_we, csr_sel, csr_wdata,
                  output csr_rdata, csr_ack);
endinterface

// File: rtl/m_ttime_half.sv
// One 32-bit counter half: load, add with carry-out, or increment.
// Priority is load > add > increment; increment wraps silently.
module m_ttime_half (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_ldata,
  input  logic        i_add,
  input  logic [5:0]  i_addend,
  input  logic        i_inc,
  output logic [31:0] o_q,
  output logic        o_co
);

  logic [31:0] r_q;
  logic [32:0] w_sum;

  assign w_sum = {1'b0, r_q} + {27'd0, i_addend};
  assign o_co  = i_add & w_sum[32];
  assign o_q   = r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_q <= 32'd0;
    else if (i_load) r_q <= i_ldata;
    else if (i_add)  r_q <= w_sum[31:0];
    else if (i_inc)  r_q <= r_q + 32'd1;
  end

endmodule

// File: rtl/m_ttime_acc.sv
// 64-bit cycle and instret accumulator: lo words add on completion, hi words
// take the carry in the following CY_C / CY_I cycles; CSR access via req/ack.
module m_ttime_acc
  import m_ttime_pkg::*;
#(
  parameter bit NO_CYCLECNT = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_corerunning,
  input  logic          i_instr_done,
  input  logic [5:0]    i_ccnt,
  m_ttime_acc_if.slave  csr,
  output logic          o_busy,
  output logic          o_ovf
);

  state_t      r_state, w_state_nxt;
  logic        r_pend_v, r_ovf, r_cc, r_ci, r_ack;
  logic [5:0]  r_pend_cnt;
  logic [31:0] r_rdata;

  logic        w_done, w_idle, w_accept, w_serve, w_wr, w_rd;
  logic        w_wr_cyc, w_wr_ins, w_cc, w_ci, w_inc_chi, w_inc_ihi;
  logic [5:0]  w_cnt;
  logic [3:0]  w_ld;
  logic [31:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;
  logic        w_cyc_lo_co, w_ins_lo_co, w_cyc_hi_co, w_ins_hi_co, w_unused_co;

  assign w_done   = i_instr_done & i_corerunning;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & (w_done | r_pend_v);
  assign w_cnt    = NO_CYCLECNT ? 6'd1 : (r_pend_v ? r_pend_cnt : i_ccnt);

  // Serving only with no pending work keeps hi reads post-carry coherent.
  assign w_serve  = w_idle & ~r_pend_v & csr.csr_req & ~r_ack;
  assign w_wr     = w_serve & csr.csr_we;
  assign w_rd     = w_serve & ~csr.csr_we;
  assign w_ld     = w_wr ? (4'b0001 << csr.csr_sel) : 4'b0000;
  assign w_wr_cyc = w_wr & ~csr.csr_sel[1];
  assign w_wr_ins = w_wr & csr.csr_sel[1];

  assign w_cc = w_cyc_lo_co & ~w_wr_cyc;
  assign w_ci = w_ins_lo_co & ~w_wr_ins;
  assign w_unused_co = w_cyc_hi_co ^ w_ins_hi_co;

  m_ttime_half u_cyc_lo (.i_clk(i_clk), .i_rst(i_rst), .i_load(w_ld[0]), .i_ldata(csr.csr_wdata),
                         .i_add(w_accept), .i_addend(w_cnt), .i_inc(1'b0),
                         .o_q(w_cyc_lo), .o_co(w_cyc_lo_co));
  m_ttime_half u_cyc_hi (.i_clk(i_clk), .i_rst(i_rst), .i_load(w_ld[1]), .i_ldata(csr.csr_wdata),
                         .i_add(1'b0), .i_addend(6'd0), .i_inc(w_inc_chi),
                         .o_q(w_cyc_hi), .o_co(w_cyc_hi_co));
  m_ttime_half u_ins_lo (.i_clk(i_clk), .i_rst(i_rst), .i_load(w_ld[2]), .i_ldata(csr.csr_wdata),
                         .i_add(w_accept), .i_addend(6'd1), .i_inc(1'b0),
                         .o_q(w_ins_lo), .o_co(w_ins_lo_co));
  m_ttime_half u_ins_hi (.i_clk(i_clk), .i_rst(i_rst), .i_load(w_ld[3]), .i_ldata(csr.csr_wdata),
                         .i_add(1'b0), .i_addend(6'd0), .i_inc(w_inc_ihi),
                         .o_q(w_ins_hi), .o_co(w_ins_hi_co));

  always_comb begin
    w_state_nxt = r_state;
    w_inc_chi   = 1'b0;
    w_inc_ihi   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_cc)      w_state_nxt = ST_CY_C;
          else if (w_ci) w_state_nxt = ST_CY_I;
        end
      end
      ST_CY_C: begin
        w_inc_chi   = 1'b1;
        w_state_nxt = r_ci ? ST_CY_I : ST_IDLE;
      end
      ST_CY_I: begin
        w_inc_ihi   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cc       <= 1'b0;
      r_ci       <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_cnt <= 6'd0;
      r_ovf      <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_serve;
      if (w_accept) begin
        r_cc <= w_cc;
        r_ci <= w_ci;
      end
      // In IDLE a buffered count is consumed first; a same-cycle completion refills it.
      if (w_idle) begin
        if (r_pend_v) begin
          r_pend_v <= w_done;
          if (w_done) r_pend_cnt <= i_ccnt;
        end
      end else if (w_done) begin
        if (r_pend_v) begin
          r_ovf <= 1'b1;
        end else begin
          r_pend_v   <= 1'b1;
          r_pend_cnt <= i_ccnt;
        end
      end
      if (w_rd) begin
        case (csr.csr_sel)
          SEL_CYC_LO: r_rdata <= w_cyc_lo;
          SEL_CYC_HI: r_rdata <= w_cyc_hi;
          SEL_INS_LO: r_rdata <= w_ins_lo;
          default:    r_rdata <= w_ins_hi;
        endcase
      end
    end
  end

  assign csr.csr_ack   = r_ack;
  assign csr.csr_rdata = r_rdata;
  assign o_busy        = ~w_idle | r_pend_v;
  assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_m_ttime_acc.sv
// Directed bench for m_ttime_acc: table of completion/CSR operations plus
// hand-written multi-cycle sequences for carries, buffering, collisions and reset.
module tb_m_ttime_acc;
  import m_ttime_pkg::*;

  localparam int OP_DONE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;

  typedef struct {
    int          op;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       corerunning = 1'b1;
  logic       done = 1'b0;
  logic [5:0] ccnt = 6'd0;
  logic       done2 = 1'b0;
  logic [5:0] ccnt2 = 6'd0;
  logic       busy, ovf, busy2, ovf2;

  int n_pass = 0;
  int n_tot  = 0;

  m_ttime_acc_if if1 ();
  m_ttime_acc_if if2 ();

  m_ttime_acc #(.NO_CYCLECNT(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_corerunning(corerunning), .i_instr_done(done),
    .i_ccnt(ccnt), .csr(if1), .o_busy(busy), .o_ovf(ovf));

  m_ttime_acc #(.NO_CYCLECNT(1'b1)) dut_nc (
    .i_clk(clk), .i_rst(rst), .i_corerunning(1'b1), .i_instr_done(done2),
    .i_ccnt(ccnt2), .csr(if2), .o_busy(busy2), .o_ovf(ovf2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic csr_xfer(input logic we, input logic [1:0] sel, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    if1.csr_req = 1'b1; if1.csr_we = we; if1.csr_sel = sel; if1.csr_wdata = wd;
    lat = 0; rd = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if1.csr_ack) begin
        lat = k; rd = if1.csr_rdata; break;
      end
    end
    if1.csr_req = 1'b0;
    if (lat == 0) begin
      n_tot++;
      $display("FAIL ack_timeout: got no ack, expected ack within 20 cycles");
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] wd);
    logic [31:0] r; int l;
    csr_xfer(1'b1, sel, wd, r, l);
  endtask

  task automatic rd_chk(input logic [1:0] sel, input logic [31:0] exp, input string nm);
    logic [31:0] r; int l;
    csr_xfer(1'b0, sel, 32'd0, r, l);
    chk(nm, r, exp);
  endtask

  task automatic rd2_chk(input logic [1:0] sel, input logic [31:0] exp, input string nm);
    logic got;
    @(negedge clk);
    if2.csr_req = 1'b1; if2.csr_we = 1'b0; if2.csr_sel = sel; if2.csr_wdata = 32'd0;
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if2.csr_ack) begin
        got = 1'b1; chk(nm, if2.csr_rdata, exp); break;
      end
    end
    if2.csr_req = 1'b0;
    if (!got) begin
      n_tot++;
      $display("FAIL %s: got no ack, expected ack", nm);
    end
  endtask

  task automatic pulse_done(input logic [5:0] c);
    @(negedge clk); done = 1'b1; ccnt = c;
    @(negedge clk); done = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] r;
    int          lat;

    tbl[0]  = '{OP_DONE, SEL_CYC_LO, 32'd5,  32'd0, "done5"};
    tbl[1]  = '{OP_DONE, SEL_CYC_LO, 32'd7,  32'd0, "done7"};
    tbl[2]  = '{OP_DONE, SEL_CYC_LO, 32'd63, 32'd0, "done63"};
    tbl[3]  = '{OP_RD, SEL_CYC_LO, 32'd0, 32'd75, "basic_cyc_lo"};
    tbl[4]  = '{OP_RD, SEL_INS_LO, 32'd0, 32'd3,  "basic_ins_lo"};
    tbl[5]  = '{OP_RD, SEL_CYC_HI, 32'd0, 32'd0,  "basic_cyc_hi"};
    tbl[6]  = '{OP_RD, SEL_INS_HI, 32'd0, 32'd0,  "basic_ins_hi"};
    tbl[7]  = '{OP_WR, SEL_INS_LO, 32'h1234, 32'd0, "wr_ins_lo"};
    tbl[8]  = '{OP_RD, SEL_INS_LO, 32'd0, 32'h1234, "rb_ins_lo"};
    tbl[9]  = '{OP_WR, SEL_CYC_HI, 32'hA5A5_0000, 32'd0, "wr_cyc_hi"};
    tbl[10] = '{OP_RD, SEL_CYC_HI, 32'd0, 32'hA5A5_0000, "rb_cyc_hi"};
    tbl[11] = '{OP_WR, SEL_INS_HI, 32'd7, 32'd0, "wr_ins_hi"};
    tbl[12] = '{OP_RD, SEL_INS_HI, 32'd0, 32'd7, "rb_ins_hi"};
    tbl[13] = '{OP_DONE, SEL_CYC_LO, 32'd20, 32'd0, "done20"};
    tbl[14] = '{OP_RD, SEL_CYC_LO, 32'd0, 32'd95, "acc_cyc_lo"};
    tbl[15] = '{OP_RD, SEL_INS_LO, 32'd0, 32'h1235, "acc_ins_lo"};

    if1.csr_req = 1'b0; if1.csr_we = 1'b0; if1.csr_sel = 2'b00; if1.csr_wdata = 32'd0;
    if2.csr_req = 1'b0; if2.csr_we = 1'b0; if2.csr_sel = 2'b00; if2.csr_wdata = 32'd0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, if1.csr_ack}, 32'd0);
    chk("rst_rdata", if1.csr_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].op == OP_DONE) begin
        pulse_done(tbl[i].data[5:0]);
      end else begin
        csr_xfer(tbl[i].op == OP_WR, tbl[i].sel, tbl[i].data, r, lat);
        chk({tbl[i].name, "_lat"}, lat, 32'd1);
        if (tbl[i].op == OP_RD) chk(tbl[i].name, r, tbl[i].exp);
      end
    end

    // low-word carry
    wr(SEL_CYC_LO, 32'hFFFF_FFFE); wr(SEL_CYC_HI, 32'd0);
    pulse_done(6'd3);
    chk("lc_busy_cy_c", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lc_busy_done", {31'd0, busy}, 32'd0);
    rd_chk(SEL_CYC_LO, 32'd1, "lc_cyc_lo");
    rd_chk(SEL_CYC_HI, 32'd1, "lc_cyc_hi");

    // double carry: CY_C then CY_I
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_INS_LO, 32'hFFFF_FFFF);
    wr(SEL_CYC_HI, 32'd0); wr(SEL_INS_HI, 32'd0);
    pulse_done(6'd1);
    chk("dc_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("dc_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("dc_busy3", {31'd0, busy}, 32'd0);
    rd_chk(SEL_CYC_LO, 32'd0, "dc_cyc_lo");
    rd_chk(SEL_INS_LO, 32'd0, "dc_ins_lo");
    rd_chk(SEL_CYC_HI, 32'd1, "dc_cyc_hi");
    rd_chk(SEL_INS_HI, 32'd1, "dc_ins_hi");

    // buffered completion during CY_C, refill in the consuming IDLE cycle
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_INS_LO, 32'd0); wr(SEL_CYC_HI, 32'd0);
    @(negedge clk); done = 1'b1; ccnt = 6'd1;
    @(negedge clk); ccnt = 6'd4;
    @(negedge clk); ccnt = 6'd10;
    @(negedge clk); done = 1'b0;
    chk("buf_busy_refill", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("buf_busy_end", {31'd0, busy}, 32'd0);
    chk("buf_ovf", {31'd0, ovf}, 32'd0);
    rd_chk(SEL_CYC_LO, 32'd14, "buf_cyc_lo");
    rd_chk(SEL_INS_LO, 32'd3, "buf_ins_lo");
    rd_chk(SEL_CYC_HI, 32'd1, "buf_cyc_hi");

    // overflow: second completion while buffered and not IDLE is dropped
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_INS_LO, 32'hFFFF_FFFF);
    wr(SEL_CYC_HI, 32'd0); wr(SEL_INS_HI, 32'd0);
    @(negedge clk); done = 1'b1; ccnt = 6'd1;
    @(negedge clk); ccnt = 6'd4;
    @(negedge clk); ccnt = 6'd9;
    chk("ovf_before", {31'd0, ovf}, 32'd0);
    chk("ovf_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk); done = 1'b0;
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("ovf_busy_end", {31'd0, busy}, 32'd0);
    rd_chk(SEL_CYC_LO, 32'd4, "ovf_cyc_lo");
    rd_chk(SEL_INS_LO, 32'd1, "ovf_ins_lo");
    rd_chk(SEL_CYC_HI, 32'd1, "ovf_cyc_hi");
    rd_chk(SEL_INS_HI, 32'd1, "ovf_ins_hi");
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // write collision with a completion
    wr(SEL_CYC_LO, 32'd0); wr(SEL_INS_LO, 32'd5);
    @(negedge clk);
    if1.csr_req = 1'b1; if1.csr_we = 1'b1; if1.csr_sel = SEL_CYC_LO; if1.csr_wdata = 32'd100;
    done = 1'b1; ccnt = 6'd9;
    @(negedge clk); done = 1'b0;
    chk("col_ack", {31'd0, if1.csr_ack}, 32'd1);
    if1.csr_req = 1'b0;
    rd_chk(SEL_CYC_LO, 32'd100, "col_cyc_lo");
    rd_chk(SEL_INS_LO, 32'd6, "col_ins_lo");

    // collision also discards the overwritten half's carry
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_CYC_HI, 32'd0);
    @(negedge clk);
    if1.csr_req = 1'b1; if1.csr_we = 1'b1; if1.csr_sel = SEL_CYC_LO; if1.csr_wdata = 32'd100;
    done = 1'b1; ccnt = 6'd9;
    @(negedge clk); done = 1'b0; if1.csr_req = 1'b0;
    chk("colc_busy", {31'd0, busy}, 32'd0);
    rd_chk(SEL_CYC_LO, 32'd100, "colc_cyc_lo");
    rd_chk(SEL_CYC_HI, 32'd0, "colc_cyc_hi");

    // read issued during CY_C is served after the carry lands
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_CYC_HI, 32'd5);
    @(negedge clk); done = 1'b1; ccnt = 6'd1;
    @(negedge clk); done = 1'b0;
    if1.csr_req = 1'b1; if1.csr_we = 1'b0; if1.csr_sel = SEL_CYC_HI;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if1.csr_ack) begin
        lat = k; r = if1.csr_rdata; break;
      end
    end
    if1.csr_req = 1'b0;
    chk("busyrd_lat", lat, 32'd2);
    chk("busyrd_data", r, 32'd6);

    // async reset in the middle of a carry
    wr(SEL_CYC_LO, 32'hFFFF_FFFF); wr(SEL_INS_LO, 32'd77);
    pulse_done(6'd1);
    chk("rmid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    rd_chk(SEL_CYC_LO, 32'd0, "rmid_cyc_lo");
    rd_chk(SEL_CYC_HI, 32'd0, "rmid_cyc_hi");
    rd_chk(SEL_INS_LO, 32'd0, "rmid_ins_lo");
    rd_chk(SEL_INS_HI, 32'd0, "rmid_ins_hi");

    // corerunning gating
    corerunning = 1'b0;
    pulse_done(6'd20);
    pulse_done(6'd20);
    corerunning = 1'b1;
    rd_chk(SEL_CYC_LO, 32'd0, "gate_cyc_lo");
    rd_chk(SEL_INS_LO, 32'd0, "gate_ins_lo");

    // NO_CYCLECNT instance counts one cycle per completion
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); done2 = 1'b1; ccnt2 = 6'd50;
      @(negedge clk); done2 = 1'b0;
    end
    rd2_chk(SEL_CYC_LO, 32'd4, "nc_cyc_lo");
    rd2_chk(SEL_INS_LO, 32'd4, "nc_ins_lo");
    chk("nc_busy", {31'd0, busy2}, 32'd0);
    chk("nc_ovf", {31'd0, ovf2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/m_ttime_acc.md
# m_ttime_acc

Accumulates the per-instruction cycle count produced by the cycle-counter stage into a 64-bit `cycle` counter, and counts retired instructions in a 64-bit `instret` counter. It sits directly downstream of the cycle counter. At each instruction boundary it consumes the 6-bit count, adds it to the low word, and propagates any carry into the high word in a following cycle. It serves CSR reads and writes of all four 32-bit halves through a req/ack handshake.

## Interface
- `NO_CYCLECNT`, 0, 1: no cycle count is available; `ccnt` is ignored and `cycle` increments by 1 per instruction.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `corerunning`  in  1  core released; when low, `instr_done` is ignored.
- `instr_done`  in  1  one-cycle pulse at instruction end; `ccnt` is valid in the same cycle.
- `ccnt`  in  6  cycles used by the finished instruction, 1..63.
- `csr_req`  in  1  CSR access request; held until `csr_ack`.
- `csr_we`  in  1  1 = write, 0 = read.
- `csr_sel`  in  2  selects the half: 00 cycle lo, 01 cycle hi, 10 instret lo, 11 instret hi.
- `csr_wdata`  in  32  write data.
- `csr_rdata`  out  32  read data, valid while `csr_ack` is high.
- `csr_ack`  out  1  one-cycle acknowledge.
- `busy`  out  1  high while a carry is pending or a completion is buffered.
- `ovf`  out  1  sticky flag: a completion was lost because the holding register was full.

## Operation
- **Registers:** `cyc_lo`, `cyc_hi`, `ins_lo`, `ins_hi` (32 bits each), plus `pend_v` and a 6-bit `pend_cnt`. All registers are 0 after reset.
- **States:** IDLE, CY_C (increment `cyc_hi`), CY_I (increment `ins_hi`).
- **IDLE, accepted completion:** when `instr_done & corerunning`, or when `pend_v` is set:
  - `cyc_lo += cnt`, zero-extended to 33 bits; `cnt` is `pend_cnt` if `pend_v`, else `ccnt`.
  - `ins_lo += 1`.
  - Each carry-out of bit 32 latches its own flag, `cc` or `ci`.
  - Next state is CY_C if `cc`, else CY_I if `ci`, else IDLE.
- **CY_C:** `cyc_hi += 1`; next state is CY_I if `ci`, else IDLE.
- **CY_I:** `ins_hi += 1`; next state is IDLE.
- **Completion arriving outside IDLE:**
  - If `pend_v` is clear, the count is stored in `pend_cnt` and `pend_v` is set. It is consumed on the first IDLE cycle, which takes priority over `instr_done` arriving in that same cycle; that new completion refills `pend`.
  - If `pend_v` is already set, the completion is dropped and `ovf` is set. `ovf` clears only on `rst`.
- **CSR service:**
  - A request is served only in IDLE with `pend_v` clear.
  - A write replaces the selected half.
  - A read loads `csr_rdata` from the selected half.
- **Write coinciding with an accepted completion in the same IDLE cycle:**
  - The written half takes `csr_wdata`.
  - The accumulation into that half is discarded, along with its carry.
  - All other halves update normally.
- **Wrap:** 64-bit overflow wraps to 0 silently; carry out of either hi word is dropped.
- **NO_CYCLECNT=1:** `cnt` is fixed at 1. Otherwise identical.

## Timing
- Lo words update on the clock edge that samples `instr_done`.
- Hi word increments complete at most 2 cycles later: CY_C, then CY_I.
- `busy` is high in CY_C and CY_I, and whenever `pend_v` is set.
- **CSR handshake:**
  - `csr_ack` rises in the cycle after `csr_req` is sampled in a serviceable IDLE cycle.
  - `csr_ack` is high for exactly 1 cycle; the requester drops `csr_req` after seeing `csr_ack`.
  - A `csr_req` still high in the ack cycle is not re-served.
- **Read coherence:** a read of a hi half returns the post-carry value.
- **Reset values:** `csr_ack`=0, `csr_rdata`=0, `busy`=0, `ovf`=0, state IDLE.
- **Asynchronous reset mid-carry:** abandons the carry; all counters read 0 afterwards.
- **Pipeline assumption:** minimum instruction length is 2 cycles, so the single holding entry suffices during normal operation.

## Structure
- **Shared package `m_ttime_pkg`:**
  - State encoding: IDLE=2'b00, CY_C=2'b01, CY_I=2'b10.
  - `csr_sel` constants: SEL_CYC_LO, SEL_CYC_HI, SEL_INS_LO, SEL_INS_HI.
- **Sub-module `m_ttime_half`:** one 32-bit register with load, add-with-carry-out and increment. It is instantiated four times; the lo instances use add, the hi instances use increment.

## Test plan
- **Basic accumulation:** reset, then `instr_done` with `ccnt`=5, 7, 63 → `cyc_lo`=75, `ins_lo`=3; reading sel 00 returns 75, with ack 1 cycle after req.
- **Low-word carry:** write `cyc_lo`=0xFFFFFFFE, then `instr_done` `ccnt`=3 → `cyc_lo`=1, `busy` high 1 cycle, `cyc_hi`=1; reading sel 01 returns 1.
- **Double carry:** write `cyc_lo`=0xFFFFFFFF and `ins_lo`=0xFFFFFFFF, then `ccnt`=1 → states CY_C then CY_I; both hi halves =1 and both lo halves =0 after 3 cycles.
- **Completions during carry:** during CY_C, `instr_done` `ccnt`=4 is buffered and then applied (`busy` held). A second `instr_done` while `pend_v` is set → `ovf`=1 and the count is dropped.
- **Write collision and read while busy:** csr write sel 00 = 100 in the same cycle as `instr_done` `ccnt`=9 → `cyc_lo`=100, `ins_lo` incremented. A read request issued during CY_C is acked only after return to IDLE.
- **Reset and gating:** assert `rst` mid-CY_C → all reads return 0. With `corerunning`=0, `instr_done` pulses leave counters unchanged. With `NO_CYCLECNT`=1, 4 completions with `ccnt`=50 → `cyc_lo`=4.
